// File: rtl/pkt_pkg.sv
// Shared definitions for the RGB line packetiser: header size, read FSM
// encoding, line-bank occupancy states and the RGB888 -> RGB565 packing.
package pkt_pkg;

  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } rd_state_t;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_t;

  // Keep the top bits of each channel: 5 red, 6 green, 5 blue.
  function automatic logic [15:0] rgb565(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Simple dual-port line store holding both ping-pong banks.
// The address is {bank, ptr}, so each bank occupies its own power-of-two half.
// The read port is registered and holds its last word while i_rd_en is low,
// which lets the packer keep a word on the output across stalled handshakes.
module line_bank_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [15:0]       i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [15:0]       o_rd_data
);

  logic [15:0] r_mem [2**ADDR_W];

  // Write port: one RGB565 word per accepted pixel.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: one-cycle registered read, held when not enabled.
  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/rgb_line_packer.sv
// Converts RGB888 pixels to RGB565, buffers one line per ping-pong bank and
// streams each completed line as a byte packet:
//   frame[15:8] frame[7:0] line[15:8] line[7:0] then hi/lo byte per pixel.
module rgb_line_packer
  import pkt_pkg::*;
#(
  parameter int IM_X = 1280,
  parameter int IM_Y = 720
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic       pixel_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       overflow
);

  localparam int PTR_W = (IM_X > 1) ? $clog2(IM_X) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(IM_X - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [15:0]      LAST_LINE = 16'(IM_Y - 1);
  localparam logic [1:0]       LAST_HDR  = 2'(HDR_BYTES - 1);

  // Bank occupancy and tags
  bank_state_t r_bank_state [2];
  logic [15:0] r_tag_frame  [2];
  logic [15:0] r_tag_line   [2];

  // Write side
  logic             r_wr_bank;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [15:0]      r_line_cnt;
  logic [15:0]      r_frame_cnt;
  logic             r_overflow;
  logic             w_wr_free;
  logic             w_accept;
  logic             w_line_done;
  logic [PTR_W-1:0] w_wr_ptr_eff;
  logic [15:0]      w_frame_eff;
  logic [15:0]      w_line_eff;

  // Read side
  rd_state_t        r_state;
  logic             r_rd_bank;
  logic [1:0]       r_hdr_idx;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_lo;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_sop;
  logic             r_out_eop;
  logic             w_hs;
  logic             w_eop_hs;
  logic             w_rd_en;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [15:0]      w_rd_data;

  // in_ready depends only on registered state, never on out_ready.
  assign w_wr_free = (r_bank_state[r_wr_bank] == BANK_FREE);
  assign w_accept  = pixel_valid && w_wr_free;

  // A frame_start in the same cycle as a pixel makes that pixel index 0 of
  // line 0 in the new frame, so the effective pointer/counters see it first.
  assign w_wr_ptr_eff = frame_start ? '0 : r_wr_ptr;
  assign w_frame_eff  = frame_start ? (r_frame_cnt + 16'd1) : r_frame_cnt;
  assign w_line_eff   = frame_start ? 16'd0 : r_line_cnt;
  assign w_line_done  = w_accept && (w_wr_ptr_eff == LAST_PTR);

  assign w_hs     = r_out_valid && out_ready;
  assign w_eop_hs = w_hs && r_out_eop;

  assign in_ready  = w_wr_free;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign overflow  = r_overflow;

  line_bank_ram #(.ADDR_W(PTR_W + 1)) u_ram (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr ({r_wr_bank, w_wr_ptr_eff}),
    .i_wr_data (rgb565(R, G, B)),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_rd_bank, w_rd_ptr}),
    .o_rd_data (w_rd_data)
  );

  // Write pointer, line/frame counters, bank tags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank      <= 1'b0;
      r_wr_ptr       <= '0;
      r_line_cnt     <= 16'd0;
      r_frame_cnt    <= 16'd0;
      r_overflow     <= 1'b0;
      r_tag_frame[0] <= 16'd0;
      r_tag_frame[1] <= 16'd0;
      r_tag_line[0]  <= 16'd0;
      r_tag_line[1]  <= 16'd0;
    end else begin
      if (frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (pixel_valid && !w_wr_free) r_overflow <= 1'b1;
      if (w_line_done) begin
        r_tag_frame[r_wr_bank] <= w_frame_eff;
        r_tag_line[r_wr_bank]  <= w_line_eff;
        r_wr_bank              <= ~r_wr_bank;
        r_wr_ptr               <= '0;
        r_line_cnt             <= (w_line_eff == LAST_LINE) ? 16'd0 : (w_line_eff + 16'd1);
      end else if (w_accept) begin
        r_wr_ptr   <= w_wr_ptr_eff + PTR_ONE;
        r_line_cnt <= w_line_eff;
      end else if (frame_start) begin
        r_wr_ptr   <= '0;
        r_line_cnt <= 16'd0;
      end
    end
  end

  // Bank occupancy: filling and draining always target different banks,
  // so both transitions can land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_state[0] <= BANK_FREE;
      r_bank_state[1] <= BANK_FREE;
    end else begin
      if (w_line_done) r_bank_state[r_wr_bank] <= BANK_FULL;
      if (w_eop_hs)    r_bank_state[r_rd_bank] <= BANK_FREE;
    end
  end

  // RAM prefetch: word 0 is fetched as the header starts; word k+1 is
  // fetched when the high byte of word k is accepted, so the RAM output is
  // ready by the time the low byte of word k is accepted.
  always_comb begin
    w_rd_en  = 1'b0;
    w_rd_ptr = '0;
    if (r_state == ST_IDLE) begin
      w_rd_en = (r_bank_state[r_rd_bank] == BANK_FULL);
    end else if ((r_state == ST_PAY) && !r_lo && w_hs && (r_rd_ptr != LAST_PTR)) begin
      w_rd_en  = 1'b1;
      w_rd_ptr = r_rd_ptr + PTR_ONE;
    end
  end

  // Read FSM with registered byte-stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_bank   <= 1'b0;
      r_hdr_idx   <= 2'd0;
      r_rd_ptr    <= '0;
      r_lo        <= 1'b0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_bank_state[r_rd_bank] == BANK_FULL) begin
            r_state     <= ST_HDR;
            r_out_valid <= 1'b1;
            r_out_sop   <= 1'b1;
            r_out_eop   <= 1'b0;
            r_out_data  <= r_tag_frame[r_rd_bank][15:8];
            r_hdr_idx   <= 2'd0;
            r_rd_ptr    <= '0;
            r_lo        <= 1'b0;
          end
        end
        ST_HDR: begin
          if (w_hs) begin
            r_out_sop <= 1'b0;
            r_hdr_idx <= r_hdr_idx + 2'd1;
            if (r_hdr_idx == LAST_HDR) begin
              r_out_data <= w_rd_data[15:8];
              r_state    <= ST_PAY;
            end else begin
              case (r_hdr_idx)
                2'd0:    r_out_data <= r_tag_frame[r_rd_bank][7:0];
                2'd1:    r_out_data <= r_tag_line[r_rd_bank][15:8];
                default: r_out_data <= r_tag_line[r_rd_bank][7:0];
              endcase
            end
          end
        end
        ST_PAY: begin
          if (w_hs) begin
            if (!r_lo) begin
              r_out_data <= w_rd_data[7:0];
              r_lo       <= 1'b1;
              r_out_eop  <= (r_rd_ptr == LAST_PTR);
            end else if (r_out_eop) begin
              r_out_valid <= 1'b0;
              r_out_eop   <= 1'b0;
              r_lo        <= 1'b0;
              r_rd_bank   <= ~r_rd_bank;
              r_state     <= ST_IDLE;
            end else begin
              r_out_data <= w_rd_data[15:8];
              r_rd_ptr   <= r_rd_ptr + PTR_ONE;
              r_lo       <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_line_packer.sv
// Directed bench for rgb_line_packer with IM_X=4, IM_Y=2.
// Stimulus pushes expected bytes into a queue; a monitor pops and compares
// on every accepted byte and checks output stability during stalls.
`timescale 1ns/1ps
module tb_rgb_line_packer;

  localparam int IM_X = 4;
  localparam int IM_Y = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] R = 8'd0;
  logic [7:0] G = 8'd0;
  logic [7:0] B = 8'd0;
  logic       pixel_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       overflow;
  logic       tog_en = 1'b0;

  always #5 clk = ~clk;

  rgb_line_packer #(.IM_X(IM_X), .IM_Y(IM_Y)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .R           (R),
    .G           (G),
    .B           (B),
    .pixel_valid (pixel_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .overflow    (overflow)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [15:0] w;
  } pix_t;

  beat_t exp_q[$];
  pix_t  tbl[8];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_hdr(input logic [15:0] f, input logic [15:0] l);
    exp_q.push_back(beat_t'({f[15:8], 1'b1, 1'b0}));
    exp_q.push_back(beat_t'({f[7:0],  1'b0, 1'b0}));
    exp_q.push_back(beat_t'({l[15:8], 1'b0, 1'b0}));
    exp_q.push_back(beat_t'({l[7:0],  1'b0, 1'b0}));
  endtask

  task automatic push_word(input logic [15:0] w, input logic last);
    exp_q.push_back(beat_t'({w[15:8], 1'b0, 1'b0}));
    exp_q.push_back(beat_t'({w[7:0],  1'b0, last}));
  endtask

  // Push a full expected packet built from four table entries.
  task automatic push_pkt(input logic [15:0] f, input logic [15:0] l,
                          input int a, input int b, input int c, input int d);
    push_hdr(f, l);
    push_word(tbl[a].w, 1'b0);
    push_word(tbl[b].w, 1'b0);
    push_word(tbl[c].w, 1'b0);
    push_word(tbl[d].w, 1'b1);
  endtask

  task automatic send(input int idx, input logic fs);
    R = tbl[idx].r;
    G = tbl[idx].g;
    B = tbl[idx].b;
    pixel_valid = 1'b1;
    frame_start = fs;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare accepted bytes against the scoreboard and check that a
  // stalled byte is held unchanged into the next cycle.
  initial begin : monitor
    beat_t exp_b;
    beat_t held;
    beat_t cur;
    logic  stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        cur = beat_t'({out_data, out_sop, out_eop});
        if (stalled) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_beat", int'(cur), int'(held));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=none", cur);
          end else begin
            exp_b = exp_q.pop_front();
            $display("beat data=%02h sop=%0d eop=%0d exp=%02h/%0d/%0d",
                     out_data, out_sop, out_eop, exp_b.data, exp_b.sop, exp_b.eop);
            check("beat", int'(cur), int'(exp_b));
          end
        end
        stalled = out_valid && !out_ready;
        held = cur;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int len;
    // Hand-computed RGB565 words.
    tbl[0] = {8'hFF, 8'hFF, 8'hFF, 16'hFFFF};
    tbl[1] = {8'hF8, 8'hFC, 8'h00, 16'hFFE0};
    tbl[2] = {8'h00, 8'h00, 8'hF8, 16'h001F};
    tbl[3] = {8'h12, 8'h34, 8'h56, 16'h11AA};
    tbl[4] = {8'h80, 8'h40, 8'h20, 16'h8204};
    tbl[5] = {8'hAB, 8'hCD, 8'hEF, 16'hAE7D};
    tbl[6] = {8'h07, 8'h03, 8'h07, 16'h0000};
    tbl[7] = {8'h08, 8'h04, 8'h08, 16'h0821};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sop", int'(out_sop), 0);
    check("rst_out_eop", int'(out_eop), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Line of white pixels, ready held high: contiguous 12-byte packet
    out_ready = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    push_pkt(16'd1, 16'd0, 0, 0, 0, 0);
    send(0, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    check("latency_pre", int'(out_valid), 0);
    @(posedge clk); #1;
    check("latency_valid", int'(out_valid), 1);
    check("latency_sop", int'(out_sop), 1);
    len = -1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_eop) begin
        len = c + 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("pkt_len", len, 12);
    wait_drain("drain_white");

    // Mixed colours with out_ready toggling every cycle
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          out_ready = ~out_ready;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join_none
    push_pkt(16'd1, 16'd1, 1, 2, 3, 4);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    wait_drain("drain_toggle");
    tog_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Downstream stalled: two lines buffered, further pixels dropped
    out_ready = 1'b0;
    push_pkt(16'd1, 16'd0, 0, 1, 2, 3);
    push_pkt(16'd1, 16'd1, 4, 5, 6, 7);
    for (int k = 0; k < 12; k++) begin
      send(k % 8, 1'b0);
      if (k == 6) check("in_ready_before_full", int'(in_ready), 1);
      if (k == 7) begin
        check("in_ready_full", int'(in_ready), 0);
        check("overflow_not_yet", int'(overflow), 0);
      end
    end
    check("overflow_set", int'(overflow), 1);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("drain_two_lines");

    // Partial line discarded by frame_start arriving with pixel 0
    push_pkt(16'd2, 16'd0, 5, 6, 7, 1);
    send(3, 1'b0);
    send(4, 1'b0);
    send(5, 1'b1);
    send(6, 1'b0);
    send(7, 1'b0);
    send(1, 1'b0);
    wait_drain("drain_frame_restart");
    check("overflow_sticky", int'(overflow), 1);

    // Reset while payload byte 6 is presented
    out_ready = 1'b0;
    push_pkt(16'd2, 16'd1, 2, 3, 4, 5);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    send(5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("pre_rst_remaining", exp_q.size(), 7);
    check("pre_rst_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_overflow", int'(overflow), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("rst_mid_valid_next", int'(out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_pkt(16'd0, 16'd0, 6, 7, 0, 1);
    send(6, 1'b0);
    send(7, 1'b0);
    send(0, 1'b0);
    send(1, 1'b0);
    wait_drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
